// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard controller: register index, controller
// state and the bundle of latch enables/flushes it drives.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DWAIT      = 2'd1,
        FLUSH_PEND = 2'd2,
        HALTED     = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic idexEn;
        logic exmemEn;
        logic memwbEn;
        logic ifidFlush;
        logic idexFlush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN = '{pcEn: 1'b1, ifidEn: 1'b1, idexEn: 1'b1,
                                      exmemEn: 1'b1, memwbEn: 1'b1,
                                      ifidFlush: 1'b0, idexFlush: 1'b0};

    localparam hz_ctrl_t CTRL_FREEZE = '{pcEn: 1'b0, ifidEn: 1'b0, idexEn: 1'b0,
                                         exmemEn: 1'b0, memwbEn: 1'b0,
                                         ifidFlush: 1'b0, idexFlush: 1'b0};

    localparam hz_ctrl_t CTRL_RESET = '{pcEn: 1'b0, ifidEn: 1'b0, idexEn: 1'b0,
                                        exmemEn: 1'b0, memwbEn: 1'b0,
                                        ifidFlush: 1'b1, idexFlush: 1'b1};

    // A load into $zero never creates a real dependency.
    function automatic logic isLoadUse(input logic memRd, input regbits_t exRt,
                                       input regbits_t idRs, input regbits_t idRt);
        return memRd && (exRt != '0) && ((exRt == idRs) || (exRt == idRt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline sequencing controller: latch enables/flushes and PC enable for the
// five-stage core, plus saturating stall/flush debug counters.
module hazard_control
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  regbits_t         ex_rt,
    input  logic             ex_memRd,
    input  logic             ex_branch_taken,
    input  logic             ihit,
    input  logic             mem_dreq,
    input  logic             dhit,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state, nextState;
    hz_ctrl_t  ctrl;
    logic      haltDone, dWait, loadUseHz, branchEv;

    always_comb begin
        haltDone  = mem_halt && (!mem_dreq || dhit);
        dWait     = mem_dreq && !dhit;
        loadUseHz = isLoadUse(ex_memRd, ex_rt, id_rs, id_rt);
        ctrl      = CTRL_FREEZE;
        nextState = state;
        branchEv  = 1'b0;

        // DWAIT needs no branch of its own: once dhit arrives it behaves as RUN.
        if (!nRST) begin
            ctrl      = CTRL_RESET;
            nextState = RUN;
        end else if (state == HALTED) begin
            nextState = HALTED;
        end else if (haltDone) begin
            nextState = HALTED;
        end else if (dWait) begin
            nextState = DWAIT;
        end else if (ex_branch_taken) begin
            ctrl           = CTRL_RUN;
            ctrl.ifidFlush = 1'b1;
            ctrl.idexFlush = 1'b1;
            branchEv       = 1'b1;
            nextState      = ihit ? RUN : FLUSH_PEND;
        end else if (state == FLUSH_PEND) begin
            // Hold PC until the wrong-path fetch returns, then discard it.
            ctrl           = CTRL_RUN;
            ctrl.pcEn      = ihit;
            ctrl.ifidFlush = 1'b1;
            nextState      = ihit ? RUN : FLUSH_PEND;
        end else if (loadUseHz) begin
            ctrl           = CTRL_RUN;
            ctrl.pcEn      = 1'b0;
            ctrl.ifidEn    = 1'b0;
            ctrl.idexFlush = 1'b1;
            nextState      = RUN;
        end else if (!ihit) begin
            ctrl           = CTRL_RUN;
            ctrl.pcEn      = 1'b0;
            ctrl.ifidFlush = 1'b1;
            nextState      = RUN;
        end else begin
            ctrl      = CTRL_RUN;
            nextState = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST)
            state <= RUN;
        else
            state <= nextState;
    end

    assign pc_en      = ctrl.pcEn;
    assign ifid_en    = ctrl.ifidEn;
    assign idex_en    = ctrl.idexEn;
    assign exmem_en   = ctrl.exmemEn;
    assign memwb_en   = ctrl.memwbEn;
    assign ifid_flush = ctrl.ifidFlush;
    assign idex_flush = ctrl.idexFlush;
    assign halt_out   = nRST && (state == HALTED);

    sat_counter #(.W(CNT_W)) uStallCnt (
        .CLK   (CLK),
        .inc   (!ctrl.pcEn && !halt_out),
        .clear (!nRST),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .CLK   (CLK),
        .inc   (branchEv),
        .clear (!nRST),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_control.sv
// Randomized check of hazard_control against a rule-level model, with a few
// directed sequences pinned to hand-computed values.
module tb_hazard_control;

    localparam int CW     = 4;
    localparam int SATMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_memRd, ex_branch_taken, ihit, mem_dreq, dhit, mem_halt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, halt_out;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_control #(.CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
        .ex_memRd(ex_memRd), .ex_branch_taken(ex_branch_taken), .ihit(ihit),
        .mem_dreq(mem_dreq), .dhit(dhit), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halt_out(halt_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model: halted flag, "wrong-path fetch still outstanding" flag, counts.
    bit       mHalted, mPend, mKnown;
    int       mStall, mFlush;
    logic [6:0] eCtrl;   // {pc, ifid, idex, exmem, memwb, ifidFlush, idexFlush}
    logic     eHalt;
    bit       eBranch;
    logic [6:0] sCtrl;
    logic     sHalt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic modelEval();
        bit haltDone, frozen, loadUse;
        haltDone = mem_halt && (!mem_dreq || dhit);
        frozen   = haltDone || (mem_dreq && !dhit);
        loadUse  = ex_memRd && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        eBranch  = 1'b0;
        eHalt    = 1'b0;
        if (!nRST)                 eCtrl = 7'b0000011;
        else if (mHalted) begin    eCtrl = 7'b0000000; eHalt = 1'b1; end
        else if (frozen)           eCtrl = 7'b0000000;
        else if (ex_branch_taken) begin eCtrl = 7'b1111111; eBranch = 1'b1; end
        else if (mPend)            eCtrl = {ihit, 6'b111110};
        else if (loadUse)          eCtrl = 7'b0011101;
        else if (!ihit)            eCtrl = 7'b0111110;
        else                       eCtrl = 7'b1111100;
    endtask

    task automatic modelAdvance();
        bit haltDone, frozen;
        haltDone = mem_halt && (!mem_dreq || dhit);
        frozen   = mem_dreq && !dhit;
        if (!nRST) begin
            mHalted = 0; mPend = 0; mStall = 0; mFlush = 0; mKnown = 1;
            return;
        end
        if (!eCtrl[6] && !eHalt && mStall < SATMAX) mStall++;
        if (eBranch && mFlush < SATMAX) mFlush++;
        if (mHalted) return;
        if (haltDone)             mHalted = 1;
        else if (frozen)          mPend = 0;
        else if (ex_branch_taken) mPend = !ihit;
        else if (mPend)           mPend = !ihit;
    endtask

    // One clock: model prediction, mid-cycle compare, edge, model update.
    task automatic step();
        modelEval();
        #4;
        sCtrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        sHalt = halt_out;
        chk("ctrl", {25'b0, sCtrl}, {25'b0, eCtrl});
        chk("halt_out", {31'b0, sHalt}, {31'b0, eHalt});
        if (mKnown) begin
            chk("stall_cnt", {28'b0, stall_cnt}, mStall);
            chk("flush_cnt", {28'b0, flush_cnt}, mFlush);
        end
        @(posedge CLK);
        modelAdvance();
        #1;
    endtask

    task automatic idle();
        nRST = 1; id_rs = 0; id_rt = 0; ex_rt = 0; ex_memRd = 0;
        ex_branch_taken = 0; ihit = 1; mem_dreq = 0; dhit = 0; mem_halt = 0;
    endtask

    task automatic doReset();
        idle(); nRST = 0;
        step();
        chk("reset_ctrl", {25'b0, sCtrl}, 32'h03);
        chk("reset_halt", {31'b0, sHalt}, 32'h0);
        chk("reset_stall", {28'b0, stall_cnt}, 32'h0);
        chk("reset_flush", {28'b0, flush_cnt}, 32'h0);
        nRST = 1;
    endtask

    initial begin
        mHalted = 0; mPend = 0; mKnown = 0; mStall = 0; mFlush = 0;
        doReset();

        // Load-use: one bubble, then free flow.
        idle(); ex_memRd = 1; ex_rt = 5; id_rs = 5;
        step();
        chk("lu_ctrl", {25'b0, sCtrl}, 32'h1D);
        idle();
        step();
        chk("lu_after", {25'b0, sCtrl}, 32'h7C);
        chk("lu_stall", {28'b0, stall_cnt}, 32'd1);

        // Load into $zero is no hazard.
        idle(); ex_memRd = 1; ex_rt = 0; id_rt = 0;
        step();
        chk("r0_ctrl", {25'b0, sCtrl}, 32'h7C);

        // Taken branch with an I-cache miss outstanding.
        idle(); ex_branch_taken = 1; ihit = 0;
        step();
        chk("br_ctrl", {25'b0, sCtrl}, 32'h7F);
        chk("br_flush", {28'b0, flush_cnt}, 32'd1);
        idle(); ihit = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fp_wait", {25'b0, sCtrl}, 32'h3E);
        end
        ihit = 1;
        step();
        chk("fp_hit", {25'b0, sCtrl}, 32'h7E);
        step();
        chk("fp_run", {25'b0, sCtrl}, 32'h7C);

        // D-cache stall holding a branch until dhit.
        doReset();
        idle(); mem_dreq = 1; ex_branch_taken = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("dw_frz", {25'b0, sCtrl}, 32'h00);
        end
        dhit = 1;
        step();
        chk("dw_hit", {25'b0, sCtrl}, 32'h7F);
        chk("dw_stall", {28'b0, stall_cnt}, 32'd5);
        chk("dw_flush", {28'b0, flush_cnt}, 32'd1);

        // Halt is sticky until reset.
        idle(); mem_halt = 1;
        step();
        chk("halt_edge", {25'b0, sCtrl}, 32'h00);
        for (int i = 0; i < 20; i++) begin
            {ex_memRd, ex_branch_taken, ihit, mem_dreq, dhit, mem_halt} = 6'($urandom);
            id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
            step();
            chk("halt_stay", {31'b0, sHalt}, 32'h1);
        end
        doReset();
        idle();
        step();
        chk("halt_clr", {31'b0, sHalt}, 32'h0);

        // Stall counter saturation.
        doReset();
        idle(); ihit = 0;
        for (int i = 0; i < 20; i++) step();
        chk("stall_sat", {28'b0, stall_cnt}, 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            nRST            = ($urandom_range(99) != 0);
            mem_halt        = ($urandom_range(199) == 0);
            mem_dreq        = ($urandom_range(3) == 0);
            dhit            = ($urandom_range(1) == 0);
            ex_branch_taken = ($urandom_range(5) == 0);
            ihit            = ($urandom_range(3) != 0);
            ex_memRd        = ($urandom_range(2) == 0);
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            ex_rt           = 5'($urandom_range(3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
